// File: rtl/window_variance.sv
// Sliding-window variance over the last 2^WINDOW_LOG2 samples.
// Four-stage pipeline producing (N*sum(x^2) - sum(x)^2) >> WINDOW_LOG2 per accepted sample.
module window_variance #(
  parameter int SAMPLE_WIDTH   = 12,
  parameter int WINDOW_LOG2    = 4,
  parameter int VARIANCE_WIDTH = 2*SAMPLE_WIDTH + WINDOW_LOG2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [SAMPLE_WIDTH-1:0]   sample,
  input  logic                      sample_valid,
  output logic [VARIANCE_WIDTH-1:0] variance,
  output logic                      variance_valid,
  output logic                      window_full
);

  localparam int N      = 1 << WINDOW_LOG2;
  localparam int SUM_W  = SAMPLE_WIDTH + WINDOW_LOG2;
  localparam int SQ_W   = 2*SAMPLE_WIDTH + WINDOW_LOG2;
  localparam int PROD_W = 2*SAMPLE_WIDTH + 2*WINDOW_LOG2;
  localparam logic [WINDOW_LOG2:0] FILL_MAX  = (WINDOW_LOG2+1)'(N);
  localparam logic [WINDOW_LOG2:0] FILL_LAST = (WINDOW_LOG2+1)'(N-1);

  logic [SAMPLE_WIDTH-1:0]   ring [N];
  logic [WINDOW_LOG2-1:0]    wr_ptr;
  logic [WINDOW_LOG2:0]      fill_count;
  logic [SAMPLE_WIDTH-1:0]   new_q;
  logic [SAMPLE_WIDTH-1:0]   old_raw;
  logic [SAMPLE_WIDTH-1:0]   old_q;
  logic                      old_zero;
  logic                      v1, c1, v2, v3;
  logic [SUM_W-1:0]          sum;
  logic [SQ_W-1:0]           sumsq;
  logic [2*SAMPLE_WIDTH-1:0] new_ext, old_ext, new_sq, old_sq;
  logic [PROD_W-1:0]         sum_ext;
  logic [PROD_W-1:0]         prod_a, prod_b, diff;

  // Buffer with registered read-before-write; the evicted value is masked
  // to zero one stage later while the window is still filling.
  always_ff @(posedge clk) begin
    if (reset && sample_valid) begin
      ring[wr_ptr] <= sample;
      old_raw      <= ring[wr_ptr];
      new_q        <= sample;
      old_zero     <= (fill_count < FILL_MAX);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr      <= '0;
      fill_count  <= '0;
      window_full <= 1'b0;
      v1          <= 1'b0;
      c1          <= 1'b0;
    end else begin
      v1 <= sample_valid;
      if (sample_valid) begin
        wr_ptr <= wr_ptr + 1'b1;
        c1     <= (fill_count >= FILL_LAST);
        if (fill_count < FILL_MAX) fill_count <= fill_count + 1'b1;
        if (fill_count >= FILL_LAST) window_full <= 1'b1;
      end
    end
  end

  assign old_q   = old_zero ? '0 : old_raw;
  assign new_ext = (2*SAMPLE_WIDTH)'(new_q);
  assign old_ext = (2*SAMPLE_WIDTH)'(old_q);
  assign new_sq  = new_ext * new_ext;
  assign old_sq  = old_ext * old_ext;
  assign sum_ext = PROD_W'(sum);
  assign diff    = prod_a - prod_b;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sum   <= '0;
      sumsq <= '0;
      v2    <= 1'b0;
      v3    <= 1'b0;
    end else begin
      if (v1) begin
        sum   <= sum + SUM_W'(new_q) - SUM_W'(old_q);
        sumsq <= sumsq + SQ_W'(new_sq) - SQ_W'(old_sq);
      end
      v2 <= v1 & c1;
      v3 <= v2;
    end
  end

  always_ff @(posedge clk) begin
    prod_a <= {sumsq, {WINDOW_LOG2{1'b0}}};
    prod_b <= sum_ext * sum_ext;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      variance       <= '0;
      variance_valid <= 1'b0;
    end else begin
      variance_valid <= v3;
      if (v3) variance <= VARIANCE_WIDTH'(diff >> WINDOW_LOG2);
    end
  end

endmodule

// File: tb/tb_window_variance.sv
// Directed bench for window_variance with a sliding-window reference model.
module tb_window_variance;
  logic        clk;
  logic        reset;
  logic [11:0] sample;
  logic        sample_valid;
  logic [27:0] variance;
  logic        variance_valid;
  logic        window_full;

  int checks = 0;
  int errors = 0;

  logic [11:0] win [16];
  int          wp;
  int          cnt;
  logic        pv   [4];
  logic [27:0] pval [4];
  logic [27:0] hold;

  window_variance dut (
    .clk(clk), .reset(reset), .sample(sample), .sample_valid(sample_valid),
    .variance(variance), .variance_valid(variance_valid), .window_full(window_full)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic logic [27:0] model_var();
    longint s = 0;
    longint q = 0;
    for (int i = 0; i < 16; i++) begin
      s += longint'(win[i]);
      q += longint'(win[i]) * longint'(win[i]);
    end
    return 28'((16*q - s*s) >> 4);
  endfunction

  // Drive one cycle at a negedge, advance the 4-deep expectation pipe, wait for next negedge.
  task automatic tick(input logic v, input logic [11:0] s);
    sample_valid = v;
    sample       = s;
    for (int i = 3; i > 0; i--) begin
      pv[i]   = pv[i-1];
      pval[i] = pval[i-1];
    end
    pv[0]   = 1'b0;
    pval[0] = '0;
    if (v) begin
      win[wp] = s;
      wp = (wp + 1) % 16;
      if (cnt < 16) cnt++;
      if (cnt == 16) begin
        pv[0]   = 1'b1;
        pval[0] = model_var();
      end
    end
    if (pv[3]) hold = pval[3];
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset        = 1'b0;
    sample_valid = 1'b0;
    wp   = 0;
    cnt  = 0;
    hold = '0;
    for (int i = 0; i < 4; i++) begin
      pv[i]   = 1'b0;
      pval[i] = '0;
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (variance_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", variance_valid); end
    checks++;
    if (variance !== 28'd0) begin errors++; $display("FAIL reset_variance: got %0d want 0", variance); end
    checks++;
    if (window_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %0b want 0", window_full); end
  endtask

  task automatic test_constant();
    logic sv[$];
    logic [11:0] ss[$];
    int pulses = 0;
    logic [27:0] last = '1;
    do_reset();
    for (int i = 0; i < 16; i++) begin sv.push_back(1'b1); ss.push_back(12'd100); end
    for (int i = 0; i < 4; i++)  begin sv.push_back(1'b0); ss.push_back(12'd0); end
    foreach (sv[i]) begin
      tick(sv[i], ss[i]);
      checks++;
      if (variance_valid !== pv[3] || variance !== hold || window_full !== (cnt == 16)) begin
        errors++;
        $display("FAIL const_cycle%0d: valid=%0b var=%0d full=%0b want valid=%0b var=%0d full=%0b",
                 i, variance_valid, variance, window_full, pv[3], hold, cnt == 16);
      end
      if (variance_valid) begin pulses++; last = variance; end
    end
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL const_pulses: got %0d want 1", pulses); end
    checks++;
    if (last !== 28'd0) begin errors++; $display("FAIL const_value: got %0d want 0", last); end
    checks++;
    if (window_full !== 1'b1) begin errors++; $display("FAIL const_full: got %0b want 1", window_full); end
  endtask

  task automatic test_alternating();
    int pulses = 0;
    logic [27:0] first = '0;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      if (i < 16) tick(1'b1, (i % 2) ? 12'd4095 : 12'd0);
      else        tick(1'b0, 12'd0);
      checks++;
      if (variance_valid !== pv[3] || variance !== hold || window_full !== (cnt == 16)) begin
        errors++;
        $display("FAIL alt_cycle%0d: valid=%0b var=%0d full=%0b want valid=%0b var=%0d full=%0b",
                 i, variance_valid, variance, window_full, pv[3], hold, cnt == 16);
      end
      if (variance_valid) begin
        if (pulses == 0) first = variance;
        pulses++;
      end
    end
    checks++;
    if (pulses != 1 || first !== 28'd67076100) begin
      errors++;
      $display("FAIL alt_first: got %0d pulses value %0d want 1 pulse value 67076100", pulses, first);
    end
  endtask

  task automatic test_eviction();
    logic sv[$];
    logic [11:0] ss[$];
    logic [27:0] got[$];
    logic [27:0] want[$];
    do_reset();
    for (int i = 0; i < 16; i++) begin sv.push_back(1'b1); ss.push_back(12'd0); end
    sv.push_back(1'b1); ss.push_back(12'd1000);
    for (int i = 0; i < 16; i++) begin sv.push_back(1'b1); ss.push_back(12'd0); end
    for (int i = 0; i < 4; i++)  begin sv.push_back(1'b0); ss.push_back(12'd0); end
    want.push_back(28'd0);
    for (int i = 0; i < 16; i++) want.push_back(28'd937500);
    want.push_back(28'd0);
    foreach (sv[i]) begin
      tick(sv[i], ss[i]);
      checks++;
      if (variance_valid !== pv[3] || variance !== hold || window_full !== (cnt == 16)) begin
        errors++;
        $display("FAIL evict_cycle%0d: valid=%0b var=%0d full=%0b want valid=%0b var=%0d full=%0b",
                 i, variance_valid, variance, window_full, pv[3], hold, cnt == 16);
      end
      if (variance_valid) got.push_back(variance);
    end
    checks++;
    if (got.size() != want.size()) begin
      errors++;
      $display("FAIL evict_count: got %0d pulses want %0d", got.size(), want.size());
    end else begin
      foreach (want[i]) begin
        checks++;
        if (got[i] !== want[i]) begin
          errors++;
          $display("FAIL evict_pulse%0d: got %0d want %0d", i, got[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_gaps();
    int pulses = 0;
    int gap;
    do_reset();
    for (int n = 0; n < 44; n++) begin
      gap = (n < 40) ? int'($urandom_range(1, 3)) : 0;
      for (int g = 0; g <= gap; g++) begin
        if (n < 40 && g == 0) tick(1'b1, 12'($urandom_range(0, 4095)));
        else                  tick(1'b0, 12'd0);
        checks++;
        if (variance_valid !== pv[3] || variance !== hold || window_full !== (cnt == 16)) begin
          errors++;
          $display("FAIL gap_s%0d_g%0d: valid=%0b var=%0d full=%0b want valid=%0b var=%0d full=%0b",
                   n, g, variance_valid, variance, window_full, pv[3], hold, cnt == 16);
        end
        if (variance_valid) pulses++;
      end
    end
    checks++;
    if (pulses != 25) begin errors++; $display("FAIL gap_pulses: got %0d want 25", pulses); end
  endtask

  task automatic test_reset_midstream();
    int pulses = 0;
    logic [27:0] last = '1;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      tick(1'b1, 12'($urandom_range(0, 4095)));
      checks++;
      if (variance_valid !== pv[3] || variance !== hold) begin
        errors++;
        $display("FAIL mid_pre%0d: valid=%0b var=%0d want valid=%0b var=%0d",
                 i, variance_valid, variance, pv[3], hold);
      end
    end
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 12'd0);
      checks++;
      if (variance_valid !== 1'b0 || variance !== 28'd0 || window_full !== 1'b0) begin
        errors++;
        $display("FAIL mid_flush%0d: valid=%0b var=%0d full=%0b want 0 0 0",
                 i, variance_valid, variance, window_full);
      end
    end
    for (int i = 0; i < 20; i++) begin
      if (i < 16) tick(1'b1, 12'd7);
      else        tick(1'b0, 12'd0);
      checks++;
      if (variance_valid !== pv[3] || variance !== hold || window_full !== (i >= 15)) begin
        errors++;
        $display("FAIL mid_post%0d: valid=%0b var=%0d full=%0b want valid=%0b var=%0d full=%0b",
                 i, variance_valid, variance, window_full, pv[3], hold, i >= 15);
      end
      if (variance_valid) begin pulses++; last = variance; end
    end
    checks++;
    if (pulses != 1 || last !== 28'd0) begin
      errors++;
      $display("FAIL mid_result: got %0d pulses value %0d want 1 pulse value 0", pulses, last);
    end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    real s, q, mean, sd, est, rv;
    do_reset();
    for (int i = 0; i < 1004; i++) begin
      if (i < 1000) tick(1'b1, 12'($urandom_range(0, 4095)));
      else          tick(1'b0, 12'd0);
      checks++;
      if (variance_valid !== pv[3] || variance !== hold || window_full !== (cnt == 16)) begin
        errors++;
        $display("FAIL b2b_cycle%0d: valid=%0b var=%0d full=%0b want valid=%0b var=%0d full=%0b",
                 i, variance_valid, variance, window_full, pv[3], hold, cnt == 16);
      end
      if (variance_valid) pulses++;
    end
    checks++;
    if (pulses != 985) begin errors++; $display("FAIL b2b_pulses: got %0d want 985", pulses); end
    s = 0.0;
    q = 0.0;
    for (int i = 0; i < 16; i++) begin
      rv = win[i];
      s += rv;
      q += rv * rv;
    end
    mean = s / 16.0;
    sd   = $sqrt(q / 16.0 - mean * mean);
    rv   = variance;
    est  = $sqrt(rv) / 4.0;
    checks++;
    if (est - sd > 0.05 || sd - est > 0.05) begin
      errors++;
      $display("FAIL b2b_stdev: got %f want %f", est, sd);
    end
  endtask

  initial begin
    reset        = 1'b0;
    sample_valid = 1'b0;
    sample       = '0;
    wp   = 0;
    cnt  = 0;
    hold = '0;
    for (int i = 0; i < 16; i++) win[i] = '0;
    for (int i = 0; i < 4; i++) begin pv[i] = 1'b0; pval[i] = '0; end
    @(negedge clk);
    test_reset();
    test_constant();
    test_alternating();
    test_eviction();
    test_gaps();
    test_reset_midstream();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
